// File: rtl/buf_loader_pkg.sv
// Shared FSM encoding, default geometry and width helper for the buffer loader.
package buf_loader_pkg;

  localparam int unsigned ARRAY_N_DEF    = 16;
  localparam int unsigned RAM_SIZE_DEF   = 1024;
  localparam int unsigned ELEM_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_LOAD = LOAD;
  localparam logic [1:0] ST_FIN  = FIN;

  // Width that holds a bank count from 0 up to and including n.
  function automatic int unsigned bank_sel_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/buf_loader_if.sv
// Stream input and buffer write port of one buffer loader.
interface buf_loader_if import buf_loader_pkg::*; #(
  parameter int unsigned ARRAY_N    = ARRAY_N_DEF,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE_DEF)
);
  logic                  s_valid;
  logic                  s_ready;
  logic [31:0]           s_data;
  logic [31:0]           ram_w_data;
  logic [ADDR_WIDTH-1:0] ram_w_addr;
  logic [ARRAY_N-1:0]    ram_w_en;

  // master: host feeding words and observing the buffer port; slave: the loader
  modport master (output s_valid, s_data,
                  input  s_ready, ram_w_data, ram_w_addr, ram_w_en);
  modport slave  (input  s_valid, s_data,
                  output s_ready, ram_w_data, ram_w_addr, ram_w_en);
endinterface

// File: rtl/buf_loader_addr_gen.sv
// Bank/row counters, wrapped buffer address, one-hot bank enable and last-element flag.
module buf_loader_addr_gen import buf_loader_pkg::*; #(
  parameter  int unsigned ARRAY_N    = ARRAY_N_DEF,
  parameter  int unsigned RAM_SIZE   = RAM_SIZE_DEF,
  parameter  int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
  localparam int unsigned NB_W       = bank_sel_w(ARRAY_N),
  localparam int unsigned RW         = ADDR_WIDTH + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [NB_W-1:0]       num_banks_i,
  input  logic [RW-1:0]         num_rows_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [ARRAY_N-1:0]    en_o,
  output logic                  last_o
);

  logic [NB_W-1:0]       bank_q, bank_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [RW-1:0]         sum;
  logic                  bank_wrap;

  assign bank_wrap = (bank_q == num_banks_i - NB_W'(1));
  assign last_o    = bank_wrap && ({1'b0, row_q} == num_rows_i - RW'(1));

  always_comb begin
    bank_d = bank_q;
    row_d  = row_q;
    if (clear_i) begin
      bank_d = '0;
      row_d  = '0;
    end else if (step_i) begin
      if (bank_wrap) begin
        bank_d = '0;
        row_d  = row_q + ADDR_WIDTH'(1);
      end else begin
        bank_d = bank_q + NB_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bank_q <= '0;
      row_q  <= '0;
    end else begin
      bank_q <= bank_d;
      row_q  <= row_d;
    end
  end

  // base and row are both below RAM_SIZE, so one conditional subtract wraps it
  assign sum    = {1'b0, base_i} + {1'b0, row_q};
  assign addr_o = (sum >= RW'(RAM_SIZE)) ? ADDR_WIDTH'(sum - RW'(RAM_SIZE))
                                         : sum[ADDR_WIDTH-1:0];
  assign en_o   = ARRAY_N'(1) << bank_q;

endmodule

// File: rtl/buf_loader.sv
// Stream-to-buffer writer: FSM, handshake and optional 4-lane unpacking.
// Build option BUF_LOADER_PACK4_EN: each stream word carries four elements.
//
// state | meaning
// IDLE  | waiting for cfg_start
// LOAD  | accepting words, issuing one buffer write per element
// FIN   | last write on the port; done follows
module buf_loader import buf_loader_pkg::*; #(
  parameter  int unsigned ARRAY_N    = ARRAY_N_DEF,
  parameter  int unsigned RAM_SIZE   = RAM_SIZE_DEF,
  parameter  int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter  int unsigned ELEM_WIDTH = ELEM_WIDTH_DEF,
  localparam int unsigned NB_W       = bank_sel_w(ARRAY_N)
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  cfg_start_i,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr_i,
  input  logic [NB_W-1:0]       cfg_num_banks_i,
  input  logic [ADDR_WIDTH:0]   cfg_num_rows_i,
  buf_loader_if.slave           bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  if (ELEM_WIDTH > 32) begin : g_elem_w_chk
    $error("ELEM_WIDTH exceeds the 32-bit stream word");
  end

  localparam logic [NB_W-1:0]     MAX_BANKS = NB_W'(ARRAY_N);
  localparam logic [ADDR_WIDTH:0] MAX_ROWS  = (ADDR_WIDTH + 1)'(RAM_SIZE);

  logic [1:0]            state_q, state_d;
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                  s_ready_q, s_ready_d;
  logic [ARRAY_N-1:0]    en_q, en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, base_q, base_d;
  logic [31:0]           data_q, data_d, wdata;
  logic [NB_W-1:0]       banks_q, banks_d;
  logic [ADDR_WIDTH:0]   rows_q, rows_d;
  logic                  cfg_legal, take_s, emit, clear, ready_load;
  logic [ADDR_WIDTH-1:0] gen_addr;
  logic [ARRAY_N-1:0]    gen_en;
  logic                  gen_last;

  assign take_s = (state_q == ST_LOAD) && bus.s_valid && s_ready_q;

`ifdef BUF_LOADER_PACK4_EN
  logic [31:0]           hold_q, hold_d;
  logic [1:0]            lanes_q, lanes_d;
  logic [ELEM_WIDTH-1:0] elem;

  // lane 0 is written straight from the handshake; lanes 1..3 drain from hold
  always_comb begin
    emit    = take_s || (lanes_q != 2'd0);
    elem    = take_s ? bus.s_data[ELEM_WIDTH-1:0] : hold_q[ELEM_WIDTH-1:0];
    wdata   = 32'(elem);
    hold_d  = hold_q;
    lanes_d = lanes_q;
    if (take_s) begin
      hold_d  = bus.s_data >> ELEM_WIDTH;
      lanes_d = 2'd3;
    end else if (emit) begin
      hold_d  = hold_q >> ELEM_WIDTH;
      lanes_d = lanes_q - 2'd1;
    end
    if ((state_q != ST_LOAD) || (emit && gen_last)) lanes_d = 2'd0;
    ready_load = (lanes_d == 2'd0);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      hold_q  <= '0;
      lanes_q <= '0;
    end else begin
      hold_q  <= hold_d;
      lanes_q <= lanes_d;
    end
  end
`else
  always_comb begin
    emit       = take_s;
    wdata      = bus.s_data;
    ready_load = 1'b1;
  end
`endif

  always_comb begin
    cfg_legal = (cfg_num_banks_i != '0) && (cfg_num_banks_i <= MAX_BANKS) &&
                (cfg_num_rows_i != '0) && (cfg_num_rows_i <= MAX_ROWS);
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    s_ready_d = s_ready_q;
    clear     = 1'b0;
    base_d    = base_q;
    banks_d   = banks_q;
    rows_d    = rows_q;
    en_d      = '0;
    addr_d    = addr_q;
    data_d    = data_q;
    if (emit) begin
      en_d   = gen_en;
      addr_d = gen_addr;
      data_d = wdata;
    end
    case (state_q)
      ST_IDLE: begin
        if (cfg_start_i) begin
          if (cfg_legal) begin
            base_d    = cfg_base_addr_i;
            banks_d   = cfg_num_banks_i;
            rows_d    = cfg_num_rows_i;
            clear     = 1'b1;
            busy_d    = 1'b1;
            s_ready_d = 1'b1;
            state_d   = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (emit && gen_last) begin
          s_ready_d = 1'b0;
          state_d   = ST_FIN;
        end else begin
          s_ready_d = ready_load;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      s_ready_q <= 1'b0;
      en_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      base_q    <= '0;
      banks_q   <= '0;
      rows_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      s_ready_q <= s_ready_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      base_q    <= base_d;
      banks_q   <= banks_d;
      rows_q    <= rows_d;
    end
  end

  buf_loader_addr_gen #(
    .ARRAY_N    (ARRAY_N),
    .RAM_SIZE   (RAM_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk_i       (clk_i),
    .rst_ni      (reset_ni),
    .clear_i     (clear),
    .step_i      (emit),
    .base_i      (base_q),
    .num_banks_i (banks_q),
    .num_rows_i  (rows_q),
    .addr_o      (gen_addr),
    .en_o        (gen_en),
    .last_o      (gen_last)
  );

  assign bus.s_ready    = s_ready_q;
  assign bus.ram_w_en   = en_q;
  assign bus.ram_w_addr = addr_q;
  assign bus.ram_w_data = data_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_buf_loader.sv
// Randomized bench for buf_loader against an element-list reference model.
module tb_buf_loader;
  import buf_loader_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [4:0]    cfg_nb = '0;
  logic [AW:0]   cfg_nr = '0;
  logic          busy, done, err;
  int            checks = 0;
  int            errors = 0;

  buf_loader_if #(.ARRAY_N(16), .ADDR_WIDTH(AW)) bus ();

  buf_loader #(.ARRAY_N(16), .RAM_SIZE(1024), .ELEM_WIDTH(8)) dut (
    .clk_i           (clk),
    .reset_ni        (reset_n),
    .cfg_start_i     (cfg_start),
    .cfg_base_addr_i (cfg_base),
    .cfg_num_banks_i (cfg_nb),
    .cfg_num_rows_i  (cfg_nr),
    .bus             (bus),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 32'(bus.s_ready), 0);
    chk({tag, "_en"}, 32'(bus.ram_w_en), 0);
    chk({tag, "_addr"}, 32'(bus.ram_w_addr), 0);
    chk({tag, "_data"}, bus.ram_w_data, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  // mode: 0 random words, 1 counting words, 2 the two fixed packed words
  task automatic run_load(input int base, input int nb, input int nr, input int vprob,
                          input int mode, input int abort_at);
    int          n, need, sent, got, cyc;
    bit          prev_hs, hs, lastw, wr, fin;
    logic [31:0] word;
    logic [31:0] exp_d[$];
    n = nb * nr;
`ifdef BUF_LOADER_PACK4_EN
    need = (n + 3) / 4;
`else
    need = n;
`endif
    sent = 0; got = 0; cyc = 0; prev_hs = 0; lastw = 0; fin = 0;
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_base = AW'(base); cfg_nb = 5'(nb); cfg_nr = (AW + 1)'(nr);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    while (!fin && cyc < 2000) begin
      if (mode == 0) word = $urandom;
      else if (mode == 1) word = 32'(sent);
      else word = (sent == 0) ? 32'h04030201 : 32'h08070605;
      bus.s_valid = ($urandom_range(99) < vprob);
      bus.s_data  = word;
      if (vprob < 100) begin
        cfg_start = !lastw && ($urandom_range(7) == 0);
        cfg_nb    = '0;
      end
      @(negedge clk);
      if (cyc == 0) begin
        chk("start_busy", 32'(busy), 1);
        chk("start_s_ready", 32'(bus.s_ready), 1);
      end
      chk("err_in_load", 32'(err), 0);
      wr = (bus.ram_w_en != '0);
      if (wr) begin
        if (got < n && got < exp_d.size()) begin
          chk("w_addr", 32'(bus.ram_w_addr), 32'((base + got / nb) % 1024));
          chk("w_en", 32'(bus.ram_w_en), 32'(1) << (got % nb));
          chk("w_data", bus.ram_w_data, exp_d[got]);
        end else begin
          chk("w_count", 32'(got + 1), 32'(n));
        end
        got++;
      end
`ifndef BUF_LOADER_PACK4_EN
      chk("w_timing", 32'(wr), 32'(prev_hs));
      if (sent < need) chk("s_ready_load", 32'(bus.s_ready), 1);
`endif
      if (sent >= need) chk("s_ready_after", 32'(bus.s_ready), 0);
      if (lastw) begin
        chk("done_pulse", 32'(done), 1);
        chk("busy_end", 32'(busy), 0);
        fin = 1;
      end else begin
        chk("done_early", 32'(done), 0);
      end
      lastw = wr && (got == n);
      hs = bus.s_valid && bus.s_ready;
      if (hs) begin
`ifdef BUF_LOADER_PACK4_EN
        for (int l = 0; l < 4; l++)
          if (exp_d.size() < n) exp_d.push_back((word >> (8 * l)) & 32'hFF);
`else
        exp_d.push_back(word);
`endif
        sent++;
      end
      prev_hs = hs;
      if (abort_at > 0 && got == abort_at && !fin) begin
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("abort");
        @(posedge clk); #1;
        reset_n = 1'b1; bus.s_valid = 1'b0; cfg_start = 1'b0;
        repeat (6) begin
          @(negedge clk);
          chk("abort_done", 32'(done), 0);
          chk("abort_en", 32'(bus.ram_w_en), 0);
          chk("abort_busy", 32'(busy), 0);
        end
        return;
      end
      if (!fin) begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    bus.s_valid = 1'b0;
    cfg_start = 1'b0;
    if (!fin) chk("load_timeout", 0, 1);
  endtask

  task automatic bad_cfg(input int nb, input int nr);
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_nb = 5'(nb); cfg_nr = (AW + 1)'(nr); cfg_base = AW'($urandom_range(1023));
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(negedge clk);
    chk("bad_err", 32'(err), 1);
    chk("bad_busy", 32'(busy), 0);
    chk("bad_s_ready", 32'(bus.s_ready), 0);
    chk("bad_en", 32'(bus.ram_w_en), 0);
    @(negedge clk);
    chk("bad_err_once", 32'(err), 0);
    chk("bad_busy2", 32'(busy), 0);
    chk("bad_en2", 32'(bus.ram_w_en), 0);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    reset_n = 1'b1;

    run_load(0, 16, 2, 100, 1, 0);
    run_load(1022, 3, 4, 100, 0, 0);
    for (int i = 0; i < 6; i++)
      run_load($urandom_range(1023), $urandom_range(1, 16), $urandom_range(1, 6),
               $urandom_range(30, 90), 0, 0);
    bad_cfg(0, 2);
    bad_cfg(17, 2);
    bad_cfg(4, 0);
    bad_cfg(4, 1025);
    run_load(0, 16, 2, 100, 1, 5);
    run_load(0, 16, 2, 100, 1, 0);
`ifdef BUF_LOADER_PACK4_EN
    run_load(0, 2, 3, 100, 2, 0);
    run_load($urandom_range(1023), 5, 3, 60, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
